// File: rtl/conv_mac_pkg.sv
// rtl/conv_mac_pkg.sv - shared widths and helpers for the conv MAC pipeline
package conv_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 16;
  localparam int DEF_DIN1_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_DOUT_WIDTH = 24;
  localparam int DEF_NUM_STAGE  = 3;
  localparam int DEF_SAT        = 1;

  // Widest accumulator the narrowing helper can handle.
  localparam int NARROW_W = 64;

  // Full-precision signed product width.
  function automatic int prod_width(input int din0_w, input int din1_w);
    return din0_w + din1_w;
  endfunction

  // Narrow a sign-extended sum to dout_w bits. Returns {ovf, value}; only
  // the low dout_w bits of value are meaningful. Overflow means the bits
  // above the result's sign bit are not a copy of it, in both modes.
  function automatic logic [NARROW_W:0] sat_narrow(
    input logic signed [NARROW_W-1:0] sum,
    input int                         dout_w,
    input bit                         sat
  );
    logic                ovf;
    logic [NARROW_W-1:0] val;
    ovf = 1'b0;
    for (int i = 0; i < NARROW_W; i++) begin
      if ((i >= dout_w - 1) && (sum[i] != sum[NARROW_W-1])) ovf = 1'b1;
    end
    val = sum;
    if (sat && ovf) begin
      for (int i = 0; i < NARROW_W; i++) begin
        val[i] = (i < dout_w - 1) ? ~sum[NARROW_W-1] : sum[NARROW_W-1];
      end
    end
    return {ovf, val};
  endfunction

endpackage

// File: rtl/conv_3_mac_stage.sv
// rtl/conv_3_mac_stage.sv - stallable operand/product register slice
module conv_3_mac_stage
  import conv_mac_pkg::*;
#(
  parameter int W = prod_width(DEF_DIN0_WIDTH, DEF_DIN1_WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d_data,
  input  logic         d_valid,
  input  logic         d_last,
  input  logic         d_acc,
  output logic [W-1:0] q_data,
  output logic         q_valid,
  output logic         q_last,
  output logic         q_acc
);

  // Advance the slice only when the pipeline is not stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      q_last  <= 1'b0;
      q_acc   <= 1'b0;
    end else if (en) begin
      q_data  <= d_data;
      q_valid <= d_valid;
      q_last  <= d_last;
      q_acc   <= d_acc;
    end
  end

endmodule

// File: rtl/conv_3_mac_pipe.sv
// rtl/conv_3_mac_pipe.sv - pipelined signed MAC with pass/accumulate modes
module conv_3_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int NUM_STAGE  = DEF_NUM_STAGE,
  parameter int SAT        = DEF_SAT
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  input  logic                         in_acc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_ovf
);

  localparam int PWID = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  if (ACC_WIDTH < PWID) begin : g_chk_acc
    $error("ACC_WIDTH must be at least DIN0_WIDTH+DIN1_WIDTH");
  end
  if (ACC_WIDTH > NARROW_W) begin : g_chk_acc_max
    $error("ACC_WIDTH exceeds the narrowing helper width");
  end
  if (DOUT_WIDTH > ACC_WIDTH || DOUT_WIDTH < 1) begin : g_chk_dout
    $error("DOUT_WIDTH must be between 1 and ACC_WIDTH");
  end
  if (NUM_STAGE < 1) begin : g_chk_stage
    $error("NUM_STAGE must be at least 1");
  end

  // Stage 0 carries the raw operand pair packed as {a, b}; the multiply sits
  // between stage 0 and stage 1 so later stages carry the product instead.
  function automatic logic signed [PWID-1:0] mul_ops(input logic [PWID-1:0] ops);
    logic signed [PWID-1:0] a;
    logic signed [PWID-1:0] b;
    a = PWID'($signed(ops[PWID-1:DIN1_WIDTH]));
    b = PWID'($signed(ops[DIN1_WIDTH-1:0]));
    return a * b;
  endfunction

  logic stall;
  logic en;

  logic [PWID-1:0] st_data  [NUM_STAGE];
  logic            st_valid [NUM_STAGE];
  logic            st_last  [NUM_STAGE];
  logic            st_acc   [NUM_STAGE];

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
    logic [PWID-1:0] d_data;
    logic            d_valid;
    logic            d_last;
    logic            d_acc;

    if (k == 0) begin : g_head
      assign d_data  = {din0, din1};
      assign d_valid = in_valid;
      assign d_last  = in_last;
      assign d_acc   = in_acc;
    end else begin : g_body
      if (k == 1) begin : g_mul
        assign d_data = mul_ops(st_data[0]);
      end else begin : g_fwd
        assign d_data = st_data[k-1];
      end
      assign d_valid = st_valid[k-1];
      assign d_last  = st_last[k-1];
      assign d_acc   = st_acc[k-1];
    end

    conv_3_mac_stage #(
      .W (PWID)
    ) u_stage (
      .clk     (ap_clk),
      .rst_n   (ap_rst_n),
      .en      (en),
      .d_data  (d_data),
      .d_valid (d_valid),
      .d_last  (d_last),
      .d_acc   (d_acc),
      .q_data  (st_data[k]),
      .q_valid (st_valid[k]),
      .q_last  (st_last[k]),
      .q_acc   (st_acc[k])
    );
  end

  logic signed [PWID-1:0]      prod_fin;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic                        fin_valid;
  logic                        fin_last;
  logic                        fin_acc;

  if (NUM_STAGE == 1) begin : g_tail_mul
    assign prod_fin = mul_ops(st_data[0]);
  end else begin : g_tail_reg
    assign prod_fin = $signed(st_data[NUM_STAGE-1]);
  end

  assign prod_ext  = ACC_WIDTH'(prod_fin);
  assign fin_valid = st_valid[NUM_STAGE-1];
  assign fin_last  = st_last[NUM_STAGE-1];
  assign fin_acc   = st_acc[NUM_STAGE-1];

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        first_q;
  logic signed [ACC_WIDTH-1:0] sum;
  logic                        res_valid_q;
  logic signed [ACC_WIDTH-1:0] res_sum_q;

  // Pass beats bypass the running sum; accumulate beats restart from zero
  // when the previous accumulation closed.
  always_comb begin
    sum = prod_ext;
    if (fin_acc) sum = (first_q ? '0 : acc_q) + prod_ext;
  end

  // Accumulate stage: update the running sum and latch a finished result.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
    end else if (en) begin
      res_valid_q <= 1'b0;
      if (fin_valid) begin
        if (!fin_acc) begin
          res_valid_q <= 1'b1;
          res_sum_q   <= sum;
        end else if (fin_last) begin
          res_valid_q <= 1'b1;
          res_sum_q   <= sum;
          acc_q       <= '0;
          first_q     <= 1'b1;
        end else begin
          acc_q   <= sum;
          first_q <= 1'b0;
        end
      end
    end
  end

  logic [NARROW_W:0] nar;
  assign nar = sat_narrow(NARROW_W'(res_sum_q), DOUT_WIDTH, SAT != 0);

  if (DOUT_WIDTH < NARROW_W) begin : g_nar_spare
    logic unused_nar;
    assign unused_nar = ^nar[NARROW_W-1:DOUT_WIDTH];
  end

  // Output register: load a narrowed result or drop valid once consumed.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= res_valid_q;
      if (res_valid_q) begin
        dout    <= $signed(nar[DOUT_WIDTH-1:0]);
        out_ovf <= nar[NARROW_W];
      end
    end
  end

endmodule
